// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the RV32 5-stage hazard controller:
//   - forwarding mux select codes for the Execute-stage operand muxes
//   - stall-engine FSM state encoding
//   - bundled stall/flush control struct and a helper that returns the
//     "frozen pipeline" control word used during reset and when disabled
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1,
        MD_BUSY  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
    } hz_ctrl_t;

    // Front end held, Execute free-running, nothing flushed.
    function automatic hz_ctrl_t hz_frozen_ctrl();
        hz_ctrl_t c;
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.stall_e = 1'b0;
        c.flush_d = 1'b0;
        c.flush_e = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// Combinational forwarding selector for one Execute-stage source operand.
// Memory-stage result wins over Writeback-stage result; x0 is never forwarded.
// Ports:
//   rs          : source register index of the operand in Execute
//   rd_m, rd_w  : destination register indices in Memory / Writeback
//   reg_write_m : Memory-stage instruction writes the register file
//   reg_write_w : Writeback-stage instruction writes the register file
//   fwd         : operand mux select (FWD_RF / FWD_WB / FWD_MEM)
// -----------------------------------------------------------------------------
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output logic [1:0]            fwd
);

    logic rs_nonzero;

    assign rs_nonzero = (rs != '0);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m == rs) && rs_nonzero) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w == rs) && rs_nonzero) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_mc
// Hazard controller for the 5-stage RV32 pipeline with a sequential stall
// engine (multi-cycle load-use bubbles, multi-cycle mul/div busy handshake),
// combinational operand forwarding and a saturating stall-cycle counter.
// Ports:
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   en                 : global enable; low freezes all state
//   Rs1D, Rs2D         : Decode-stage source registers
//   Rs1E, Rs2E, RdE    : Execute-stage source / destination registers
//   RdM, RdW           : Memory / Writeback destination registers
//   RegWriteE/M/W      : per-stage register write enables
//   ResultSrcE0        : Execute-stage instruction is a load
//   PCSrcE             : taken branch / jump resolved in Execute
//   MulDivE            : multi-cycle mul/div occupies Execute
//   MulDivDone         : mul/div result valid this cycle
//   stall_clr          : clears stall_cnt
//   ForwardAE/BE       : Execute operand mux selects
//   StallF/D/E         : hold PC, IF/ID, ID/EX
//   FlushD/E           : bubble IF/ID, ID/EX
//   stall_cnt          : saturating count of front-end stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int COUNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  ResultSrcE0,
    input  logic                  PCSrcE,
    input  logic                  MulDivE,
    input  logic                  MulDivDone,
    input  logic                  stall_clr,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [COUNT_W-1:0]    stall_cnt
);

    // The first bubble is issued from IDLE, so the counter only tracks the rest.
    localparam logic [2:0] LCNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

    hz_state_t          state;
    hz_state_t          state_n;
    logic [2:0]         lcnt;
    logic [2:0]         lcnt_n;
    hz_ctrl_t           eng;
    logic               lu;
    logic               redirect;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    assign lu = ResultSrcE0 && RegWriteE && (RdE != '0) &&
                ((Rs1D == RdE) || (Rs2D == RdE));

    // A redirect cannot coexist with a mul/div in Execute; if it ever does,
    // the mul/div handshake keeps ownership of the pipeline.
    assign redirect = PCSrcE && (state != MD_BUSY) && !MulDivE;

    // Next-state and stall-engine outputs
    always_comb begin
        state_n = state;
        lcnt_n  = lcnt;
        eng     = '0;
        case (state)
            IDLE: begin
                if (MulDivE && !MulDivDone) begin
                    eng.stall_f = 1'b1;
                    eng.stall_d = 1'b1;
                    eng.stall_e = 1'b1;
                    state_n     = MD_BUSY;
                end else if (lu) begin
                    eng.stall_f = 1'b1;
                    eng.stall_d = 1'b1;
                    eng.flush_e = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        lcnt_n  = LCNT_INIT;
                        state_n = LD_STALL;
                    end
                end
            end
            LD_STALL: begin
                eng.stall_f = 1'b1;
                eng.stall_d = 1'b1;
                eng.flush_e = 1'b1;
                lcnt_n      = lcnt - 3'd1;
                if (lcnt == 3'd1) begin
                    state_n = IDLE;
                end
            end
            MD_BUSY: begin
                if (MulDivDone) begin
                    state_n = IDLE;
                end else begin
                    eng.stall_f = 1'b1;
                    eng.stall_d = 1'b1;
                    eng.stall_e = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                lcnt_n  = '0;
            end
        endcase

        // Redirect squashes the dependent instruction anyway, so any pending
        // load-use bubble (started or about to start) is dropped.
        if (redirect) begin
            eng.stall_f = 1'b0;
            eng.stall_d = 1'b0;
            eng.flush_d = 1'b1;
            eng.flush_e = 1'b1;
            state_n     = IDLE;
            lcnt_n      = '0;
        end
    end

    // Output stage: reset and disable override the engine with a frozen front end
    always_comb begin
        if (rst || !en) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            {StallF, StallD, StallE, FlushD, FlushE} = hz_frozen_ctrl();
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            {StallF, StallD, StallE, FlushD, FlushE} = eng;
        end
    end

    // State, load-bubble counter and stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lcnt      <= '0;
            stall_cnt <= '0;
        end else if (en) begin
            state <= state_n;
            lcnt  <= lcnt_n;
            if (stall_clr) begin
                stall_cnt <= '0;
            end else if (eng.stall_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       ResultSrcE0, PCSrcE, MulDivE, MulDivDone, stall_clr;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE;
    logic [3:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl_mc #(
        .REG_ADDR_W        (5),
        .LOAD_STALL_CYCLES (3),
        .COUNT_W           (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteE   (RegWriteE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .MulDivE     (MulDivE),
        .MulDivDone  (MulDivDone),
        .stall_clr   (stall_clr),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Redirect and mul/div in Execute are exclusive by decode.
    always @(posedge clk) begin
        if (PCSrcE && MulDivE) begin
            n_fail++;
            $display("FAIL decode_excl: PCSrcE=%b MulDivE=%b required not both high", PCSrcE, MulDivE);
        end
    end

    // regs = {Rs1D,Rs2D,Rs1E,Rs2E,RdE,RdM,RdW}
    // ctl  = {RegWriteE,RegWriteM,RegWriteW,ResultSrcE0,PCSrcE,MulDivE,MulDivDone,en,rst}
    // exp  = {ForwardAE,ForwardBE,StallF,StallD,StallE,FlushD,FlushE}
    typedef struct {
        string       nm;
        logic [34:0] regs;
        logic [8:0]  ctl;
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input string nm, input logic [34:0] regs,
                                input logic [8:0] ctl, input logic [8:0] exp);
        vec_t v;
        v.nm = nm; v.regs = regs; v.ctl = ctl; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] obs();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", nm, act[8:0], exp[8:0]);
        end
    endtask

    task automatic drive(input logic [34:0] regs, input logic [8:0] ctl);
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = regs;
        {RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE, MulDivDone, en, rst} = ctl;
    endtask

    task automatic quiet();
        drive('0, 9'b0000000_1_0);
        stall_clr = 1'b0;
    endtask

    // Called at a negedge; returns at the next negedge with rst released.
    task automatic reset_dut();
        quiet();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk("fwd_a_mem",  {5'd0,5'd0,5'd5,5'd0,5'd0,5'd5,5'd5}, 9'b011_0000_10, 9'b10_00_00000);
        vecs[1]  = mk("fwd_a_wb",   {5'd0,5'd0,5'd5,5'd0,5'd0,5'd5,5'd5}, 9'b001_0000_10, 9'b01_00_00000);
        vecs[2]  = mk("fwd_a_x0",   {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 9'b011_0000_10, 9'b00_00_00000);
        vecs[3]  = mk("fwd_b_mem",  {5'd0,5'd0,5'd0,5'd9,5'd0,5'd9,5'd9}, 9'b011_0000_10, 9'b00_10_00000);
        vecs[4]  = mk("fwd_b_wb",   {5'd0,5'd0,5'd0,5'd9,5'd0,5'd3,5'd9}, 9'b011_0000_10, 9'b00_01_00000);
        vecs[5]  = mk("fwd_both",   {5'd0,5'd0,5'd3,5'd4,5'd0,5'd3,5'd4}, 9'b011_0000_10, 9'b10_01_00000);
        vecs[6]  = mk("fwd_nomatch",{5'd0,5'd0,5'd6,5'd6,5'd0,5'd5,5'd7}, 9'b011_0000_10, 9'b00_00_00000);
        vecs[7]  = mk("lu_rs1",     {5'd7,5'd0,5'd0,5'd0,5'd7,5'd0,5'd0}, 9'b100_1000_10, 9'b00_00_11001);
        vecs[8]  = mk("lu_rs2",     {5'd0,5'd7,5'd0,5'd0,5'd7,5'd0,5'd0}, 9'b100_1000_10, 9'b00_00_11001);
        vecs[9]  = mk("lu_x0",      {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 9'b100_1000_10, 9'b00_00_00000);
        vecs[10] = mk("lu_nowrite", {5'd0,5'd7,5'd0,5'd0,5'd7,5'd0,5'd0}, 9'b000_1000_10, 9'b00_00_00000);
        vecs[11] = mk("lu_noload",  {5'd0,5'd7,5'd0,5'd0,5'd7,5'd0,5'd0}, 9'b100_0000_10, 9'b00_00_00000);
        vecs[12] = mk("branch",     {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 9'b000_0100_10, 9'b00_00_00011);
        vecs[13] = mk("lu_branch",  {5'd0,5'd7,5'd0,5'd0,5'd7,5'd0,5'd0}, 9'b100_1100_10, 9'b00_00_00011);
        vecs[14] = mk("md_1cycle",  {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 9'b000_0011_10, 9'b00_00_00000);
        vecs[15] = mk("md_start",   {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0}, 9'b000_0010_10, 9'b00_00_11100);
        vecs[16] = mk("en_off",     {5'd0,5'd0,5'd5,5'd0,5'd0,5'd5,5'd5}, 9'b011_0010_00, 9'b00_00_11000);
        vecs[17] = mk("rst_on",     {5'd0,5'd0,5'd5,5'd0,5'd0,5'd5,5'd5}, 9'b011_0100_11, 9'b00_00_11000);

        quiet();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs", 32'(obs()), 32'(9'b00_00_00000));
        chk("reset_cnt", 32'(stall_cnt), 32'd0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            reset_dut();
            drive(vecs[i].regs, vecs[i].ctl);
            #1;
            chk(vecs[i].nm, 32'(obs()), 32'(vecs[i].exp));
        end

        // Load-use with three bubbles
        @(negedge clk);
        reset_dut();
        ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1 chk("ld3_c1", 32'(obs()), 32'(9'b00_00_11001));
        @(negedge clk);
        ResultSrcE0 = 1'b0; RegWriteE = 1'b0; RdE = 5'd0;
        #1 chk("ld3_c2", 32'(obs()), 32'(9'b00_00_11001));
        @(negedge clk);
        #1 chk("ld3_c3", 32'(obs()), 32'(9'b00_00_11001));
        @(negedge clk);
        #1 chk("ld3_c4_idle", 32'(obs()), 32'(9'b00_00_00000));
        chk("ld3_cnt", 32'(stall_cnt), 32'd3);

        // Branch on the second load-use bubble
        @(negedge clk);
        reset_dut();
        ResultSrcE0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1 chk("ldbr_c1", 32'(obs()), 32'(9'b00_00_11001));
        @(negedge clk);
        ResultSrcE0 = 1'b0; RegWriteE = 1'b0; RdE = 5'd0; PCSrcE = 1'b1;
        #1 chk("ldbr_c2_redirect", 32'(obs()), 32'(9'b00_00_00011));
        @(negedge clk);
        PCSrcE = 1'b0;
        #1 chk("ldbr_c3_idle", 32'(obs()), 32'(9'b00_00_00000));
        chk("ldbr_cnt", 32'(stall_cnt), 32'd1);

        // Mul/div held four cycles, done on the fourth
        @(negedge clk);
        reset_dut();
        MulDivE = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1 chk($sformatf("md4_c%0d", c), 32'(obs()), 32'(9'b00_00_11100));
            @(negedge clk);
        end
        MulDivDone = 1'b1;
        #1 chk("md4_c4_done", 32'(obs()), 32'(9'b00_00_00000));
        @(negedge clk);
        MulDivE = 1'b0; MulDivDone = 1'b0;
        #1 chk("md4_after", 32'(obs()), 32'(9'b00_00_00000));
        chk("md4_cnt", 32'(stall_cnt), 32'd3);

        // Reset in the middle of MD_BUSY
        @(negedge clk);
        reset_dut();
        MulDivE = 1'b1;
        @(negedge clk);
        #1 chk("mdrst_busy", 32'(obs()), 32'(9'b00_00_11100));
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mdrst_during_rst", 32'(obs()), 32'(9'b00_00_11000));
        @(negedge clk);
        rst = 1'b0; MulDivE = 1'b0;
        #1 chk("mdrst_idle", 32'(obs()), 32'(9'b00_00_00000));
        chk("mdrst_cnt", 32'(stall_cnt), 32'd0);

        // Counter saturation, enable freeze, clear-over-increment
        @(negedge clk);
        reset_dut();
        MulDivE = 1'b1;
        repeat (20) @(negedge clk);
        MulDivDone = 1'b1;
        #1 chk("sat_cnt", 32'(stall_cnt), 32'd15);
        @(negedge clk);
        MulDivE = 1'b0; MulDivDone = 1'b0; en = 1'b0;
        #1 chk("en_off_outputs", 32'(obs()), 32'(9'b00_00_11000));
        @(negedge clk);
        #1 chk("en_off_hold_cnt", 32'(stall_cnt), 32'd15);
        @(negedge clk);
        en = 1'b1; MulDivE = 1'b1; stall_clr = 1'b1;
        #1 chk("clr_stall_out", 32'(obs()), 32'(9'b00_00_11100));
        @(negedge clk);
        stall_clr = 1'b0; MulDivDone = 1'b1;
        #1 chk("clr_wins_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        quiet();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
